miriscv_lsu: RTL and testbench

Load/store unit between the miriscv core's execute stage and the data port of the on-chip RAM. It converts a core load/store request (address, funct3 size code, store data) into one word-aligned memory transaction with byte enables and lane-replicated write data. It stalls the core until the memory returns `data_rvalid_i`, then delivers the sign- or zero-extended load result. Misaligned or illegal-size requests are rejected without touching memory.

---
 rtl/miriscv_lsu.sv | 172 +++++++++++++++++
 tb/tb_miriscv_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns a core load/store into one word-aligned data-port
// transaction and stalls the core until the memory response returns.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  addr_lo_q;
  logic [2:0]  size_q;
  logic        we_q;

  logic        size_b;
  logic        size_h;
  logic        size_w;
  logic        size_bu;
  logic        size_hu;
  logic        misaligned;
  logic        illegal;
  logic        fault_cond;
  logic        req_valid;
  logic        issue;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // Request decode
  assign size_b  = (lsu_size_i == SIZE_B);
  assign size_h  = (lsu_size_i == SIZE_H);
  assign size_w  = (lsu_size_i == SIZE_W);
  assign size_bu = (lsu_size_i == SIZE_BU);
  assign size_hu = (lsu_size_i == SIZE_HU);

  assign misaligned = ((size_h | size_hu) & lsu_addr_i[0]) |
                      (size_w & (lsu_addr_i[1:0] != 2'b00));
  assign illegal    = lsu_we_i ? ~(size_b | size_h | size_w)
                               : ~(size_b | size_h | size_w | size_bu | size_hu);
  assign fault_cond = misaligned | illegal;

  // Memory handshake: data_req_o is held until data_gnt_i is seen in the same
  // cycle; the access then completes on the first data_rvalid_i in WAIT.
  assign req_valid = lsu_req_i & ~fault_cond & ~rst_n_i;
  assign issue     = (state_q == IDLE) & req_valid & data_gnt_i;

  always_comb begin
    be = 4'b1111;
    case (lsu_size_i[1:0])
      2'b00:   be = 4'b0001 << lsu_addr_i[1:0];
      2'b01:   be = 4'b0011 << lsu_addr_i[1:0];
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    wdata = lsu_data_i;
    case (lsu_size_i[1:0])
      2'b00:   wdata = {4{lsu_data_i[7:0]}};
      2'b01:   wdata = {2{lsu_data_i[15:0]}};
      default: wdata = lsu_data_i;
    endcase
  end

  assign rdata_shifted = data_rdata_i >> {addr_lo_q, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    case (size_q)
      SIZE_B:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_BU: load_ext = {24'h000000, rdata_shifted[7:0]};
      SIZE_H:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      SIZE_HU: load_ext = {16'h0000, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      addr_lo_q <= 2'b00;
      size_q    <= 3'b000;
      we_q      <= 1'b0;
    end else if (issue) begin
      addr_lo_q <= lsu_addr_i[1:0];
      size_q    <= lsu_size_i;
      we_q      <= lsu_we_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && data_gnt_i) state_d = WAIT;
      WAIT:    if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is asserted
  always_comb begin
    lsu_data_o      = 32'h0;
    lsu_stall_req_o = 1'b0;
    lsu_fault_o     = 1'b0;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_addr_o     = 32'h0;
    data_wdata_o    = 32'h0;
    if (!rst_n_i) begin
      case (state_q)
        IDLE: begin
          lsu_fault_o = lsu_req_i & fault_cond;
          if (req_valid) begin
            data_req_o      = 1'b1;
            lsu_stall_req_o = 1'b1;
            data_we_o       = lsu_we_i;
            data_be_o       = be;
            data_addr_o     = {lsu_addr_i[31:2], 2'b00};
            data_wdata_o    = wdata;
          end
        end
        WAIT: begin
          lsu_stall_req_o = ~data_rvalid_i;
          if (data_rvalid_i && !we_q) begin
            lsu_data_o = load_ext;
          end
        end
        default: begin
          lsu_stall_req_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu against a small behavioural RAM with
// combinational grant and a one-cycle (optionally two-cycle) response.
module tb_miriscv_lsu;

  logic        clk;
  logic        rst;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        lsu_fault;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  logic        gnt_allow;
  logic        slow_rsp;
  logic        init_mem;
  logic        pend1;
  logic        pend2;
  logic [31:0] rdata_q;
  logic [31:0] mem [64];

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_n_i         (rst),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata),
    .lsu_data_o      (lsu_rdata),
    .lsu_stall_req_o (lsu_stall),
    .lsu_fault_o     (lsu_fault),
    .data_req_o      (data_req),
    .data_gnt_i      (data_gnt),
    .data_rvalid_i   (data_rvalid),
    .data_rdata_i    (data_rdata),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_addr_o     (data_addr),
    .data_wdata_o    (data_wdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM
  assign data_gnt    = data_req && gnt_allow;
  assign data_rvalid = slow_rsp ? pend2 : pend1;
  assign data_rdata  = rdata_q;

  always @(posedge clk) begin
    pend1 <= data_req && data_gnt;
    pend2 <= pend1;
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[6'h15] <= 32'h8070F0A5;
      mem[6'h16] <= 32'hCAFE5A3C;
      mem[6'h17] <= 32'h01234567;
    end else if (data_req && data_gnt) begin
      rdata_q <= mem[data_addr[7:2]];
      if (data_we) begin
        for (int b = 0; b < 4; b++)
          if (data_be[b]) mem[data_addr[7:2]][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access; the expected load result goes through the scoreboard
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input int gdelay, input string tag);
    int  n_stall;
    int  n_req;
    bit  done;
    exp_q.push_back(exp_rd);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = size;
    lsu_addr  = addr;
    lsu_wdata = wd;
    gnt_allow = (gdelay == 0);
    n_stall   = 0;
    n_req     = 0;
    done      = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk({tag, "_req"}, {31'h0, data_req}, 32'h1);
        chk({tag, "_we"}, {31'h0, data_we}, {31'h0, we});
        chk({tag, "_be"}, {28'h0, data_be}, {28'h0, exp_be});
        chk({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
        chk({tag, "_wdata"}, data_wdata, exp_wd);
      end
      if (data_req) n_req++;
      if (lsu_stall) begin
        n_stall++;
      end else begin
        chk({tag, "_rdata"}, lsu_rdata, exp_q.pop_front());
        done = 1'b1;
      end
      tick();
      if (c + 1 >= gdelay) gnt_allow = 1'b1;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    if (!done) void'(exp_q.pop_front());
    chk({tag, "_stall_cycles"}, n_stall, 1 + gdelay);
    chk({tag, "_req_cycles"}, n_req, 1 + gdelay);
    lsu_req   = 1'b0;
    gnt_allow = 1'b1;
  endtask

  task automatic fault_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input string tag);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = size;
    lsu_addr  = addr;
    lsu_wdata = 32'h11223344;
    @(negedge clk);
    chk({tag, "_fault"}, {31'h0, lsu_fault}, 32'h1);
    chk({tag, "_req"}, {31'h0, data_req}, 32'h0);
    chk({tag, "_stall"}, {31'h0, lsu_stall}, 32'h0);
    tick();
    lsu_req = 1'b0;
    @(negedge clk);
    chk({tag, "_fault_clr"}, {31'h0, lsu_fault}, 32'h0);
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    init_mem  = 1'b1;
    gnt_allow = 1'b1;
    slow_rsp  = 1'b0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    lsu_size  = 3'b010;
    lsu_addr  = 32'h0;
    lsu_wdata = 32'h0;
    tick();
    tick();

    // Reset values, then a valid request held during reset is gated
    @(negedge clk);
    chk("rst_req", {31'h0, data_req}, 32'h0);
    chk("rst_stall", {31'h0, lsu_stall}, 32'h0);
    chk("rst_fault", {31'h0, lsu_fault}, 32'h0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_be", {28'h0, data_be}, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_we", {31'h0, data_we}, 32'h0);
    tick();
    lsu_req  = 1'b1;
    lsu_addr = 32'h54;
    @(negedge clk);
    chk("rst_gate_req", {31'h0, data_req}, 32'h0);
    chk("rst_gate_stall", {31'h0, lsu_stall}, 32'h0);
    tick();
    rst      = 1'b0;
    init_mem = 1'b0;
    lsu_req  = 1'b0;
    tick();

    // Loads from word 0x54 = 0x8070F0A5
    access(1'b0, 3'b010, 32'h54, 32'h0, 4'b1111, 32'h0, 32'h8070F0A5, 0, "lw54");
    access(1'b0, 3'b000, 32'h54, 32'h0, 4'b0001, 32'h0, 32'hFFFFFFA5, 0, "lb54");
    access(1'b0, 3'b100, 32'h55, 32'h0, 4'b0010, 32'h0, 32'h000000F0, 0, "lbu55");
    access(1'b0, 3'b001, 32'h56, 32'h0, 4'b1100, 32'h0, 32'hFFFF8070, 0, "lh56");
    access(1'b0, 3'b101, 32'h56, 32'h0, 4'b1100, 32'h0, 32'h00008070, 0, "lhu56");

    // Stores and read-back
    access(1'b1, 3'b000, 32'h59, 32'h00000011, 4'b0010, 32'h11111111, 32'h0, 0, "sb59");
    access(1'b0, 3'b010, 32'h58, 32'h0, 4'b1111, 32'h0, 32'hCAFE113C, 0, "lw58a");
    access(1'b1, 3'b001, 32'h5A, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, "sh5a");
    access(1'b0, 3'b010, 32'h58, 32'h0, 4'b1111, 32'h0, 32'hBEEF113C, 0, "lw58b");
    access(1'b1, 3'b010, 32'h5C, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0, "sw5c");
    access(1'b0, 3'b000, 32'h5F, 32'h0, 4'b1000, 32'h0, 32'hFFFFFFDE, 0, "lb5f");

    // Rejected requests
    fault_req(1'b0, 3'b010, 32'h52, "flw52");
    fault_req(1'b0, 3'b001, 32'h53, "flh53");
    fault_req(1'b1, 3'b011, 32'h50, "fsb011");
    fault_req(1'b1, 3'b100, 32'h50, "fsbu");
    fault_req(1'b0, 3'b111, 32'h50, "fl111");

    // Withheld grant, then a random-address word load
    access(1'b0, 3'b101, 32'h54, 32'h0, 4'b0011, 32'h0, 32'h0000F0A5, 3, "gdly3");
    begin
      logic [31:0] ra;
      ra = {24'h0, 2'b01, 4'($urandom_range(5, 7)), 2'b00};
      access(1'b0, 3'b010, ra, 32'h0, 4'b1111, 32'h0,
             (ra[7:2] == 6'h15) ? 32'h8070F0A5 :
             (ra[7:2] == 6'h16) ? 32'hBEEF113C : 32'hDEADBEEF, 0, "lwrand");
    end

    // Reset while waiting; the late response must be ignored
    tick();
    tick();
    slow_rsp = 1'b1;
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = 3'b010;
    lsu_addr = 32'h54;
    @(negedge clk);
    chk("rw_req", {31'h0, data_req}, 32'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall", {31'h0, lsu_stall}, 32'h0);
    chk("rw_rst_req", {31'h0, data_req}, 32'h0);
    tick();
    rst     = 1'b0;
    lsu_req = 1'b0;
    @(negedge clk);
    chk("rw_late_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("rw_late_stall", {31'h0, lsu_stall}, 32'h0);
    chk("rw_late_rdata", lsu_rdata, 32'h0);
    chk("rw_late_req", {31'h0, data_req}, 32'h0);
    tick();
    slow_rsp = 1'b0;
    tick();
    access(1'b0, 3'b010, 32'h54, 32'h0, 4'b1111, 32'h0, 32'h8070F0A5, 0, "lw_after_rst");

    chk("exp_q_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
